multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style control FSM for the 16-bit simplified MIPS multicycle datapath.
- It is the upstream driver of the datapath ALU. It sequences fetch, decode, execute, memory and writeback.
- It issues the 4-bit ALU operation code and the datapath mux/enable strobes, and consumes the ALU zero flag for branch resolution.
- Memory accesses use a ready handshake. A retired-instruction counter and a sticky illegal-opcode flag are included for debug.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  4  IR[15:12], stable from end of FETCH until next FETCH.
- zero  in  1  ALU zero flag for the current ALU operation.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR load enable.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  address select: 0 = PC, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = A register.
- alu_src_b  out  2  00 = B, 01 = const 1, 10 = sign-ext imm, 11 = sign-ext imm (branch offset).
- alu_control  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1101 NAND.
- pc_source  out  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
- state  out  4  current state encoding, for debug.
- illegal  out  1  sticky flag: an illegal opcode has been decoded.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Opcodes:
  - R-type: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 NAND, 6 SLT.
  - Other: 7 ADDI, 8 LW, 9 SW, A BEQ, B BNE, C J.
  - D-F are illegal.
- State encodings: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, ADDR 4, MEM_RD 5, MEM_WR 6, WB_MEM 7, WB_ALU 8, BRANCH 9, JUMP 10.
- Registers: state, illegal, retired. All other outputs are combinational from state, plus opcode/zero where stated.
- Unlisted outputs are 0 in every state. alu_control defaults to 0010.
- Reset:
  - While rst is high, every output is forced to 0, including alu_control = 0000.
  - Next state = FETCH, illegal = 0, retired = 0.
  - Reset asserted in any state, including mid-memory-wait, aborts the instruction. There is no retire and no further strobes.
- FETCH:
  - Outputs: mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, ADD.
  - ir_write = pc_write = mem_ready, pc_source = 00.
  - Holds while mem_ready = 0; goes to DECODE when mem_ready = 1.
- DECODE:
  - Outputs: alu_src_a = 0, alu_src_b = 11, ADD (branch target to ALUOut).
  - Next state by opcode: 0-6 go to EXEC_R; 7 to EXEC_I; 8/9 to ADDR; A/B to BRANCH; C to JUMP.
  - D-F go to FETCH and set illegal. That instruction is not retired.
- EXEC_R:
  - Outputs: alu_src_a = 1, alu_src_b = 00.
  - alu_control maps opcode 0..6 to 0010, 0110, 0000, 0001, 1100, 1101, 0111.
  - Next state: WB_ALU.
- EXEC_I: alu_src_a = 1, alu_src_b = 10, ADD; next state WB_ALU.
- ADDR: alu_src_a = 1, alu_src_b = 10, ADD; next state MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: mem_read = 1, iord = 1; holds until mem_ready, then goes to WB_MEM.
- MEM_WR:
  - Outputs: mem_write = 1, iord = 1.
  - Holds until mem_ready, then goes to FETCH and retires.
- WB_MEM: reg_write = 1, reg_dst = 0, mem_to_reg = 1; goes to FETCH and retires.
- WB_ALU: reg_write = 1, reg_dst = (opcode <= 6), mem_to_reg = 0; goes to FETCH and retires.
- BRANCH:
  - Outputs: alu_src_a = 1, alu_src_b = 00, SUB, pc_source = 01.
  - pc_write = (BEQ & zero) | (BNE & ~zero).
  - Goes to FETCH and retires whether or not the branch is taken.
- JUMP: pc_source = 10, pc_write = 1; goes to FETCH and retires.
- Retired counter:
  - Increments by 1 on the clock edge that leaves a retiring state.
  - Wraps from all-ones to 0.
- illegal clears only on rst.
- Cycles per instruction with mem_ready tied high:
  - R-type/ADDI 4, LW 5, SW 4, BEQ/BNE 3, J 3.
  - Each memory-wait cycle adds 1.

Test Plan:
- Reset: rst high for 2 cycles mid-MEM_RD with mem_ready = 0 → all outputs 0; after release state = 0, mem_read = 1, retired = 0, illegal = 0.
- R-type sweep: mem_ready = 1, opcodes 0..6 in turn → each passes 0→1→2→8→0. alu_control in EXEC_R = 0010, 0110, 0000, 0001, 1100, 1101, 0111; reg_dst = 1 in WB_ALU; retired = 7.
- LW with mem_ready low 3 cycles in FETCH and 2 in MEM_RD:
  - ir_write/pc_write assert only in the ready cycle.
  - MEM_RD holds 2 extra cycles.
  - WB_MEM shows reg_write = 1, mem_to_reg = 1.
  - Total 10 cycles, retired +1.
- Branches:
  - BEQ with zero = 1 → pc_write = 1, pc_source = 01.
  - BEQ with zero = 0 → pc_write = 0.
  - BNE with zero = 0 → pc_write = 1.
  - All three retire.
- Illegal: opcode E → DECODE → FETCH, illegal = 1 sticky across a following ADD, retired unchanged by E.
- Wrap: CNT_W = 4, 17 J instructions → retired goes 15 → 0 → 1.

Source files
------------

// File: rtl/multicycle_control.sv
// ============================================================================
// Module   : multicycle_control
// Purpose  : Moore control FSM for the 16-bit simplified MIPS multicycle
//            datapath. Sequences fetch/decode/execute/memory/writeback,
//            drives ALU op and datapath strobes, counts retired
//            instructions and flags illegal opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_control #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             iord,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_control,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_MEM = 4'd7,
        S_WB_ALU = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10
    } state_t;

    localparam logic [3:0] C_ALU_AND  = 4'b0000;
    localparam logic [3:0] C_ALU_OR   = 4'b0001;
    localparam logic [3:0] C_ALU_ADD  = 4'b0010;
    localparam logic [3:0] C_ALU_SUB  = 4'b0110;
    localparam logic [3:0] C_ALU_SLT  = 4'b0111;
    localparam logic [3:0] C_ALU_NOR  = 4'b1100;
    localparam logic [3:0] C_ALU_NAND = 4'b1101;

    localparam logic [3:0] C_OP_ADDI = 4'h7;
    localparam logic [3:0] C_OP_LW   = 4'h8;
    localparam logic [3:0] C_OP_SW   = 4'h9;
    localparam logic [3:0] C_OP_BEQ  = 4'hA;
    localparam logic [3:0] C_OP_BNE  = 4'hB;
    localparam logic [3:0] C_OP_J    = 4'hC;

    state_t           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             w_retire;

    // State, sticky illegal flag and retired counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    // Next-state selection; w_retire marks the edge leaving a retiring state
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        w_retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode <= 4'h6) begin
                    state_d = S_EXEC_R;
                end else begin
                    case (opcode)
                        C_OP_ADDI:         state_d = S_EXEC_I;
                        C_OP_LW, C_OP_SW:  state_d = S_ADDR;
                        C_OP_BEQ, C_OP_BNE: state_d = S_BRANCH;
                        C_OP_J:            state_d = S_JUMP;
                        default: begin
                            // Unused opcodes abandon the instruction unretired
                            state_d   = S_FETCH;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_I: state_d = S_WB_ALU;
            S_ADDR: begin
                state_d = (opcode == C_OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_WB_MEM;
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_WB_MEM, S_WB_ALU, S_BRANCH, S_JUMP: begin
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        retired_d = w_retire ? (retired_q + CNT_W'(1)) : retired_q;
    end

    // Moore datapath strobes; everything is held at zero while rst is high
    always_comb begin
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        alu_control = C_ALU_ADD;
        pc_source   = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                case (opcode)
                    4'h0:    alu_control = C_ALU_ADD;
                    4'h1:    alu_control = C_ALU_SUB;
                    4'h2:    alu_control = C_ALU_AND;
                    4'h3:    alu_control = C_ALU_OR;
                    4'h4:    alu_control = C_ALU_NOR;
                    4'h5:    alu_control = C_ALU_NAND;
                    4'h6:    alu_control = C_ALU_SLT;
                    default: alu_control = C_ALU_ADD;
                endcase
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
                reg_dst   = (opcode <= 4'h6);
            end
            S_BRANCH: begin
                alu_src_a   = 1'b1;
                alu_control = C_ALU_SUB;
                pc_source   = 2'b01;
                pc_write    = ((opcode == C_OP_BEQ) &&  zero) ||
                              ((opcode == C_OP_BNE) && !zero);
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_write    = 1'b0;
            ir_write    = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            iord        = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            alu_control = 4'b0000;
            pc_source   = 2'b00;
        end
    end

    // Debug outputs read as zero during reset like every other output
    always_comb begin
        state   = rst ? 4'd0 : state_q;
        illegal = illegal_q & ~rst;
        retired = rst ? '0 : retired_q;
    end

endmodule

`default_nettype wire
